// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor datapath.
//   DATA_W       : datapath width
//   SEL_A/SEL_B  : demux select encodings
//   slot_state_e : state of a 1-entry holding slot
package proc_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1x2_pipe_if.sv
// Handshake bundle of the 1-to-2 demux: one producer channel and two consumer channels.
//   master : producer/consumer side (drives in_*, a_ready, b_ready)
//   slave  : demux side (drives in_ready, a_valid/a_data, b_valid/b_data)
interface demux_1x2_pipe_if
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding slot with valid/ready drain.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : write load_data into the slot this cycle (caller guarantees the slot is
//               empty or draining in the same cycle)
//   load_data : word to capture
//   ready     : downstream consumer takes the held word
//   valid     : slot holds a word
//   data      : held word (registered)
module demux_out_slot
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SlotEmpty;
      data  <= '0;
    end else begin
      unique case (state)
        SlotEmpty: begin
          if (load) begin
            state <= SlotFull;
            data  <= load_data;
          end
        end
        SlotFull: begin
          // A load while full is only possible when the held word drains this cycle,
          // so the slot stays full with the new word (no bubble).
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= SlotEmpty;
          end
        end
      endcase
    end
  end

  assign valid = (state == SlotFull);

endmodule

// File: rtl/demux_1x2_pipe.sv
// Registered 1-to-2 data demultiplexer with valid/ready handshake on every channel.
// in_sel steers each accepted word into the output A or B slot; each slot holds one word.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : handshake bundle (slave side), see demux_1x2_pipe_if
//   cnt_clr  : synchronous clear of both transfer counters
//   a_cnt    : words delivered on A
//   b_cnt    : words delivered on B
// Optional feature: define DEMUX_CNT_EN to build the per-output transfer counters; otherwise
// a_cnt/b_cnt are tied to 0 and cnt_clr is ignored.
module demux_1x2_pipe
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  demux_1x2_pipe_if.slave     bus,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    a_cnt,
  output logic [CNT_W-1:0]    b_cnt
);

  logic             fire_in;
  logic             load_a;
  logic             load_b;
  logic             a_valid;
  logic             b_valid;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;

  // Ready depends only on the selected slot and its consumer, never on in_valid.
  assign bus.in_ready = (bus.in_sel == SEL_B) ? (!b_valid || bus.b_ready)
                                              : (!a_valid || bus.a_ready);

  assign fire_in = bus.in_valid && bus.in_ready;
  assign load_a  = fire_in && (bus.in_sel == SEL_A);
  assign load_b  = fire_in && (bus.in_sel == SEL_B);

  demux_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (bus.in_data),
    .ready     (bus.a_ready),
    .valid     (a_valid),
    .data      (a_data)
  );

  demux_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (bus.in_data),
    .ready     (bus.b_ready),
    .valid     (b_valid),
    .data      (b_data)
  );

  assign bus.a_valid = a_valid;
  assign bus.a_data  = a_data;
  assign bus.b_valid = b_valid;
  assign bus.b_data  = b_data;

`ifdef DEMUX_CNT_EN
  logic             drain_a;
  logic             drain_b;
  logic [CNT_W-1:0] a_cnt_q;
  logic [CNT_W-1:0] b_cnt_q;

  assign drain_a = a_valid && bus.a_ready;
  assign drain_b = b_valid && bus.b_ready;

  // Clear wins over a same-cycle increment; increments wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else if (cnt_clr) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (drain_a) a_cnt_q <= a_cnt_q + 1'b1;
      if (drain_b) b_cnt_q <= b_cnt_q + 1'b1;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

endmodule
